// File: rtl/fft_pkg.sv
// Shared widths, Q1.15 twiddle constants and fixed-point helpers for the FFT/IFFT butterflies.
package fft_pkg;

  localparam int WIDTH = 32;
  localparam int HALF  = 16;
  localparam int ACCW  = 34;

  localparam logic signed [ACCW-1:0] QMAX = 34'sd32767;
  localparam logic signed [ACCW-1:0] QMIN = -34'sd32768;

  // Packed {re, im} twiddles for e^{-j*2*pi*k/8}, k = 0..3.
  localparam logic [WIDTH-1:0] W0     = {16'sh7FFF, 16'sh0000};
  localparam logic [WIDTH-1:0] W1     = {16'sh5A82, 16'shA57E};
  localparam logic [WIDTH-1:0] WNEG_J = {16'sh0000, 16'sh8000};
  localparam logic [WIDTH-1:0] W2     = WNEG_J;
  localparam logic [WIDTH-1:0] W3     = {16'shA57E, 16'shA57E};

  function automatic logic signed [HALF-1:0] sat16(input logic signed [ACCW-1:0] x);
    if (x > QMAX)
      return 16'sh7FFF;
    else if (x < QMIN)
      return 16'sh8000;
    else
      return x[HALF-1:0];
  endfunction

  // Add half an LSB of the result, then floor-shift: ties round towards +inf.
  function automatic logic signed [ACCW-1:0] round_half_up(input logic signed [ACCW-1:0] acc,
                                                           input int sh);
    return (acc + (ACCW'(1) <<< (sh - 1))) >>> sh;
  endfunction

  // (s+1)>>>1 of a 17-bit sum always fits 16 bits, so sat16 never engages here.
  function automatic logic signed [HALF-1:0] scale_half(input logic signed [HALF:0] s);
    return sat16((ACCW'(s) + ACCW'(1)) >>> 1);
  endfunction

endpackage

// File: rtl/ifft_butterfly_pipe_cmul_conj.sv
// Two-register complex multiply of a 17-bit difference by conj(W): products in S2, round/saturate in S3.
module cmul_conj
  import fft_pkg::*;
#(
  parameter int SH = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [HALF:0]    d_re,
  input  logic signed [HALF:0]    d_im,
  input  logic [WIDTH-1:0]        w,
  output logic [WIDTH-1:0]        y
);

  logic signed [HALF-1:0]   w_re, w_im;
  logic signed [2*HALF:0]   p_rr, p_ii, p_ir, p_ri;
  logic signed [ACCW-1:0]   acc_re, acc_im;

  assign w_re = w[WIDTH-1:HALF];
  assign w_im = w[HALF-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      p_rr <= '0;
      p_ii <= '0;
      p_ir <= '0;
      p_ri <= '0;
      y    <= '0;
    end else if (en) begin
      p_rr <= 33'(d_re) * 33'(w_re);
      p_ii <= 33'(d_im) * 33'(w_im);
      p_ir <= 33'(d_im) * 33'(w_re);
      p_ri <= 33'(d_re) * 33'(w_im);
      y    <= {sat16(round_half_up(acc_re, SH)), sat16(round_half_up(acc_im, SH))};
    end
  end

  // Multiplying by conj(W) flips the sign of the imaginary twiddle terms.
  always_comb begin
    acc_re = ACCW'(p_rr) + ACCW'(p_ii);
    acc_im = ACCW'(p_ir) - ACCW'(p_ri);
  end

endmodule

// File: rtl/ifft_butterfly_pipe.sv
// 3-stage radix-2 inverse DIF butterfly: sum = A+B, diff = (A-B)*conj(W).
// Build option FFT_SCALE_EN halves every output (1/N normalization across the IFFT).
module ifft_butterfly_pipe
  import fft_pkg::*;
#(
  parameter int WIDTH = fft_pkg::WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [WIDTH-1:0]  W,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  sum,
  output logic [WIDTH-1:0]  diff
);

`ifdef FFT_SCALE_EN
  localparam int DIFF_SH = 16;
`else
  localparam int DIFF_SH = 15;
`endif

  // Handshake: a word moves when valid && ready on the same edge. The whole pipe
  // advances together on en; when S3 holds an unaccepted result everything freezes,
  // so out_valid/sum/diff stay stable until taken and in_ready drops that cycle.
  logic en;
  logic s1_valid, s2_valid, s3_valid;
  logic signed [HALF:0] a_re, a_im, b_re, b_im;
  logic signed [HALF:0] s1_sre, s1_sim, s1_dre, s1_dim;
  logic signed [HALF:0] s2_sre, s2_sim;
  logic [WIDTH-1:0]     s1_w;
  logic [WIDTH-1:0]     sum_next;

  assign en        = !s3_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = s3_valid;

  assign a_re = {A[WIDTH-1], A[WIDTH-1:HALF]};
  assign a_im = {A[HALF-1],  A[HALF-1:0]};
  assign b_re = {B[WIDTH-1], B[WIDTH-1:HALF]};
  assign b_im = {B[HALF-1],  B[HALF-1:0]};

`ifdef FFT_SCALE_EN
  always_comb sum_next = {scale_half(s2_sre), scale_half(s2_sim)};
`else
  always_comb sum_next = {sat16(ACCW'(s2_sre)), sat16(ACCW'(s2_sim))};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_sre   <= '0;
      s1_sim   <= '0;
      s1_dre   <= '0;
      s1_dim   <= '0;
      s1_w     <= '0;
      s2_sre   <= '0;
      s2_sim   <= '0;
      sum      <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sre   <= a_re + b_re;
      s1_sim   <= a_im + b_im;
      s1_dre   <= a_re - b_re;
      s1_dim   <= a_im - b_im;
      s1_w     <= W;
      s2_valid <= s1_valid;
      s2_sre   <= s1_sre;
      s2_sim   <= s1_sim;
      s3_valid <= s2_valid;
      sum      <= sum_next;
    end
  end

  cmul_conj #(
    .SH (DIFF_SH)
  ) u_cmul (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .d_re (s1_dre),
    .d_im (s1_dim),
    .w    (s1_w),
    .y    (diff)
  );

endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// Directed bench for ifft_butterfly_pipe; expected values follow FFT_SCALE_EN when defined.
module tb_ifft_butterfly_pipe;
  import fft_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] A, B, W, sum, diff;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int          got_cyc_q[$];

  ifft_butterfly_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .W         (W),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .diff      (diff)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // output monitor: records every completed output transfer
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_q.push_back({sum, diff});
      got_cyc_q.push_back(cyc);
    end
  end

  function automatic logic [31:0] cplx(input int re, input int im);
    logic [31:0] r;
    r = {re[15:0], im[15:0]};
    return r;
  endfunction

  function automatic longint sx(input logic [15:0] v);
    logic signed [15:0] t;
    t = v;
    return longint'(t);
  endfunction

  function automatic logic [15:0] clip(input longint v);
    longint c;
    c = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
    return c[15:0];
  endfunction

  // reference butterfly in plain integer arithmetic
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] w);
    longint sr, si, dr, di, wr, wi, re, im;
    int sh;
    sr = sx(a[31:16]) + sx(b[31:16]);
    si = sx(a[15:0])  + sx(b[15:0]);
    dr = sx(a[31:16]) - sx(b[31:16]);
    di = sx(a[15:0])  - sx(b[15:0]);
    wr = sx(w[31:16]);
    wi = sx(w[15:0]);
`ifdef FFT_SCALE_EN
    sh = 16;
    sr = (sr + 1) >>> 1;
    si = (si + 1) >>> 1;
`else
    sh = 15;
`endif
    re = dr * wr + di * wi;
    im = di * wr - dr * wi;
    re = (re + (longint'(1) <<< (sh - 1))) >>> sh;
    im = (im + (longint'(1) <<< (sh - 1))) >>> sh;
    return {clip(sr), clip(si), clip(re), clip(im)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // driver: one operand into an empty pipe, verify exact 3-cycle latency
  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] w, input logic [31:0] es, input logic [31:0] ed);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    A = a;
    B = b;
    W = w;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    W = $urandom;
    tick();
    check({tag, "_early"}, 64'(out_valid), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_diff"}, 64'(diff), 64'(ed));
    tick();
    check({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  logic [31:0] bp_a[6], bp_b[6], bp_w[6];
  logic [31:0] wtab[4];
  logic [31:0] e_sum, e_diff, e_tj_diff, e_sat_sum;
  logic [63:0] hold;
  int          idx, stall, guard, c0;
  bit          seen, take;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; W = '0;
    repeat (3) tick();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_diff", 64'(diff), 64'd0);
    rst = 1'b0;
    check("reset_in_ready", 64'(in_ready), 64'd1);

`ifdef FFT_SCALE_EN
    e_sum = 32'h0096_FFF4;      // 150 - 12j
    e_diff = 32'hFFCE_003E;     // -50 + 62j
    e_tj_diff = 32'hFFC2_FFCE;  // -62 - 50j
`else
    e_sum = 32'h012C_FFE7;      // 300 - 25j
    e_diff = 32'hFF9C_007D;     // -100 + 125j
    e_tj_diff = 32'hFF83_FF9C;  // -125 - 100j
`endif
    e_sat_sum = 32'h7FFF_7FFF;

    directed("basic", 32'h0064_0032, 32'h00C8_FFB5, W0, e_sum, e_diff);
    directed("twid_negj", 32'h0064_0032, 32'h00C8_FFB5, WNEG_J, e_sum, e_tj_diff);
    directed("sat", 32'h7FFF_7FFF, 32'h7FFF_7FFF, W0, e_sat_sum, 32'h0);

    // backpressure: 6 operands, 5-cycle stall at first out_valid
    bp_a[0] = cplx(32767, 32767);   bp_b[0] = cplx(-32768, 32767);  bp_w[0] = WNEG_J;
    bp_a[1] = cplx(-32768, -32768); bp_b[1] = cplx(32767, 32767);   bp_w[1] = WNEG_J;
    bp_a[2] = cplx(1000, -2000);    bp_b[2] = cplx(-3000, 4000);    bp_w[2] = W1;
    bp_a[3] = cplx(-1, 1);          bp_b[3] = cplx(1, -1);          bp_w[3] = W0;
    bp_a[4] = cplx(12345, -23456);  bp_b[4] = cplx(-6789, 9876);    bp_w[4] = W3;
    bp_a[5] = cplx(0, 0);           bp_b[5] = cplx(-32768, -32768); bp_w[5] = W0;
    got_q.delete(); got_cyc_q.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(model(bp_a[i], bp_b[i], bp_w[i]));
    idx = 0; seen = 0; stall = 0; guard = 0;
    while (got_q.size() < 6 && guard < 100) begin
      if (!seen && out_valid) begin
        seen = 1;
        stall = 5;
        hold = {sum, diff};
      end
      out_ready = (stall == 0);
      in_valid = (idx < 6);
      A = (idx < 6) ? bp_a[idx] : $urandom;
      B = (idx < 6) ? bp_b[idx] : $urandom;
      W = (idx < 6) ? bp_w[idx] : $urandom;
      @(negedge clk);
      if (stall > 0) begin
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_hold", {sum, diff}, hold);
      end
      take = in_valid && in_ready;
      tick();
      if (take) idx++;
      if (stall > 0) stall--;
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    check("bp_count", 64'(got_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      check($sformatf("bp_result%0d", i), got_q[i], exp_q[i]);

    // full-rate stream of 16
    wtab[0] = W0; wtab[1] = W1; wtab[2] = WNEG_J; wtab[3] = W3;
    got_q.delete(); got_cyc_q.delete(); exp_q.delete();
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      A = cplx(i * 2000 - 16000, 30000 - i * 3500);
      B = cplx(700 - i * 1500, i * 4000 - 32768);
      W = wtab[i % 4];
      exp_q.push_back(model(A, B, W));
      check($sformatf("fr_in_ready%0d", i), 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    check("fr_count", 64'(got_q.size()), 64'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      check($sformatf("fr_result%0d", i), got_q[i], exp_q[i]);
      check($sformatf("fr_cycle%0d", i), 64'(got_cyc_q[i]), 64'(c0 + 3 + i));
    end

    // reset with 3 operands in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      A = cplx(i * 111 + 5, -i * 222);
      B = cplx(-i * 333, i * 444 + 7);
      W = W1;
      tick();
    end
    in_valid = 1'b0;
    check("mid_full", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum", 64'(sum), 64'd0);
    check("mid_rst_diff", 64'(diff), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    got_q.delete(); got_cyc_q.delete();
    check("mid_in_ready", 64'(in_ready), 64'd1);
    repeat (6) tick();
    check("mid_no_stale", 64'(got_q.size()), 64'd0);
    directed("post_rst", 32'h0064_0032, 32'h00C8_FFB5, W0, e_sum, e_diff);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
